// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC engine.
// ring_idx walks the data circular buffer backwards from the newest sample.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WAIT_X = 3'd2,
        ST_MAC    = 3'd3,
        ST_OUT    = 3'd4
    } fir_state_e;

    localparam int NTAP_DEF   = 11;
    localparam int DW_DEF     = 32;
    localparam int AW_DEF     = 12;
    localparam int ADDR_SHIFT = 2;
    localparam int IW         = 8;

    // Both operands are already below n, so one conditional wrap is enough.
    function automatic logic [IW-1:0] ring_idx(input logic [IW-1:0] ptr,
                                                input logic [IW-1:0] k,
                                                input logic [IW-1:0] n);
        logic [IW-1:0] r;
        if (ptr >= k) begin
            r = ptr - k;
        end else begin
            r = ptr + n - k;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable.
// The sum keeps only the low DW bits and wraps; no saturation.
module fir_mac_unit #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] acc_o
);

    logic signed [2*DW-1:0] prod_s;
    logic [DW-1:0]          acc_d;
    logic [DW-1:0]          acc_q;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        prod_s = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
        if (clr_i) begin
            acc_d = {DW{1'b0}};
        end else if (en_i) begin
            acc_d = acc_q + prod_s[DW-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= {DW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_engine.sv
// FIR compute stage: stores x into a circular data BRAM, streams taps and
// history back with one-cycle read latency, accumulates and emits y.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int NTAP = NTAP_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          axis_clk,
    input  logic          axis_rst,
    input  logic          start,
    input  logic [31:0]   data_length,
    output logic          busy,
    output logic          done,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    output logic          ss_tready,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    output logic          sm_tlast,
    input  logic          sm_tready,
    output logic          tap_EN,
    output logic [AW-1:0] tap_A,
    input  logic [DW-1:0] tap_Do,
    output logic          data_EN,
    output logic [3:0]    data_WE,
    output logic [AW-1:0] data_A,
    output logic [DW-1:0] data_Di,
    input  logic [DW-1:0] data_Do
);

    localparam logic [IW-1:0] NTAP_I  = IW'(NTAP);
    localparam logic [IW-1:0] K_LAST  = IW'(NTAP - 1);
    localparam logic [IW-1:0] K_DRAIN = IW'(NTAP);
    localparam logic [IW-1:0] K_DONE  = IW'(NTAP + 1);
    localparam logic [IW-1:0] ONE_I   = IW'(1);

    fir_state_e    state_q;
    logic [31:0]   len_q;
    logic [31:0]   cnt_q;
    logic [IW-1:0] k_q;
    logic [IW-1:0] wr_ptr_q;
    logic          busy_q;
    logic          done_q;
    logic          ss_tready_q;
    logic          sm_tvalid_q;
    logic          sm_tlast_q;
    logic [DW-1:0] sm_tdata_q;

    logic          acc_clr_s;
    logic          acc_en_s;
    logic [DW-1:0] acc_s;

    function automatic logic [AW-1:0] word_addr(input logic [IW-1:0] idx);
        return AW'(idx) << ADDR_SHIFT;
    endfunction

    // Operands of issue k-1 are on Do while k is 1..NTAP.
    assign acc_clr_s = ss_tready_q & ss_tvalid;
    assign acc_en_s  = (state_q == ST_MAC) && (k_q != {IW{1'b0}}) && (k_q <= K_DRAIN);

    fir_mac_unit #(.DW(DW)) u_mac (
        .clk_i (axis_clk),
        .rst_i (axis_rst),
        .clr_i (acc_clr_s),
        .en_i  (acc_en_s),
        .a_i   (tap_Do),
        .b_i   (data_Do),
        .acc_o (acc_s)
    );

    // BRAM bus decode; the drain cycle keeps EN high so the last read is not gated off.
    always_comb begin
        tap_EN  = 1'b0;
        tap_A   = {AW{1'b0}};
        data_EN = 1'b0;
        data_WE = 4'h0;
        data_A  = {AW{1'b0}};
        data_Di = {DW{1'b0}};
        case (state_q)
            ST_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(k_q);
            end
            ST_WAIT_X: begin
                data_EN = 1'b1;
                data_WE = 4'hF & {4{ss_tvalid}};
                data_A  = word_addr(wr_ptr_q);
                data_Di = ss_tdata;
            end
            ST_MAC: begin
                if (k_q < NTAP_I) begin
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                    tap_A   = word_addr(k_q);
                    data_A  = word_addr(ring_idx(wr_ptr_q, k_q, NTAP_I));
                end else if (k_q == K_DRAIN) begin
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                end else begin
                    tap_EN  = 1'b0;
                    data_EN = 1'b0;
                end
            end
            default: begin
                tap_EN  = 1'b0;
                data_EN = 1'b0;
            end
        endcase
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= 32'd0;
            cnt_q       <= 32'd0;
            k_q         <= {IW{1'b0}};
            wr_ptr_q    <= {IW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ss_tready_q <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tlast_q  <= 1'b0;
            sm_tdata_q  <= {DW{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (data_length == 32'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            len_q   <= data_length;
                            cnt_q   <= 32'd0;
                            k_q     <= {IW{1'b0}};
                            busy_q  <= 1'b1;
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (k_q == K_LAST) begin
                        k_q         <= {IW{1'b0}};
                        wr_ptr_q    <= {IW{1'b0}};
                        ss_tready_q <= 1'b1;
                        state_q     <= ST_WAIT_X;
                    end else begin
                        k_q <= k_q + ONE_I;
                    end
                end
                ST_WAIT_X: begin
                    if (ss_tvalid) begin
                        ss_tready_q <= 1'b0;
                        k_q         <= {IW{1'b0}};
                        state_q     <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (k_q == K_DONE) begin
                        sm_tvalid_q <= 1'b1;
                        sm_tdata_q  <= acc_s;
                        sm_tlast_q  <= ((cnt_q + 32'd1) == len_q);
                        cnt_q       <= cnt_q + 32'd1;
                        wr_ptr_q    <= (wr_ptr_q == K_LAST) ? {IW{1'b0}} : wr_ptr_q + ONE_I;
                        state_q     <= ST_OUT;
                    end else begin
                        k_q <= k_q + ONE_I;
                    end
                end
                ST_OUT: begin
                    if (sm_tready) begin
                        sm_tvalid_q <= 1'b0;
                        if (sm_tlast_q) begin
                            sm_tlast_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            ss_tready_q <= 1'b1;
                            state_q     <= ST_WAIT_X;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ss_tready = ss_tready_q;
    assign sm_tvalid = sm_tvalid_q;
    assign sm_tdata  = sm_tdata_q;
    assign sm_tlast  = sm_tlast_q;

endmodule
